spi_slave_sequencer: RTL and testbench

- Clock-domain sequencer for the SPI slave datapath: shift register, address latch, data memory and MISO tri-state buffer.
- Synchronizes the raw SPI pins (sclk, cs_n, mosi) into clk and detects sclk edges.
- Runs an 8-bit address/command phase, then an 8-bit read or write data phase.
- Issues single-cycle strobes (shift, address latch, shift-register parallel load, memory write) and holds the MISO buffer enable.

---
 rtl/spi_slave_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sequencer.sv
// spi_slave_sequencer
//   Clock-domain control sequencer for an SPI slave datapath. The raw SPI pins
//   are synchronized into clk and sclk/cs_n edges are detected. A frame is an
//   8-bit command phase followed by an 8-bit read or write data phase. The
//   frame outputs are single-cycle strobes to the shift register, the address
//   latch and the data memory, plus a level enable for the MISO buffer.
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   sclk_in      raw SPI clock pin
//   cs_n_in      raw chip select pin, active low
//   mosi_in      raw MOSI pin
//   mosi_s       synchronized MOSI to the shift register serial input
//   sr_shift     strobe: shift register shifts one bit
//   addr_we      strobe: address latch loads sr[7:1]
//   sr_we        strobe: shift register parallel-loads memory read data
//   dm_we        strobe: data memory write of sr at the latched address
//   buf_e        MISO buffer enable (level)
//   busy         a frame is in progress
//   frame_err    pulse: cs_n deasserted before the frame completed
module spi_slave_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_BITS   = 7,
    parameter int DATA_BITS   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_in,
    input  logic cs_n_in,
    input  logic mosi_in,
    output logic mosi_s,
    output logic sr_shift,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic buf_e,
    output logic busy,
    output logic frame_err
);

    // The counter also has to hold the command-phase count, so size it for
    // whichever phase is longer.
    localparam int CNT_MAX = (DATA_BITS > ADDR_BITS + 1) ? DATA_BITS : ADDR_BITS + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, CMD, LATCH, RLOAD, RDATA, WDATA, COMMIT, DONE
    } state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic rw, rw_nxt;

    // Synchronizers; reset values match an idle bus (sclk low, cs_n high).
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_d, cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // sclk edges only count while the slave is selected.
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rw    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rw    <= rw_nxt;
        end
    end

    // Outputs decode from the registered state and the edge pulses. A cs_n
    // rise is checked before anything else so that an abort drops a
    // coincident sclk edge and suppresses the strobe of the current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rw_nxt    = rw;
        sr_shift  = 1'b0;
        addr_we   = 1'b0;
        sr_we     = 1'b0;
        dm_we     = 1'b0;
        buf_e     = 1'b0;
        frame_err = 1'b0;

        if (state != IDLE && cs_rise) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            frame_err = (state != DONE) && !(state == RDATA && cnt == DATA_LAST);
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt = CMD;
                        cnt_nxt   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        sr_shift = 1'b1;
                        if (cnt == CMD_LAST) begin
                            // last command bit is the R/W flag
                            rw_nxt    = mosi_s;
                            cnt_nxt   = '0;
                            state_nxt = LATCH;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end
                LATCH: begin
                    addr_we   = 1'b1;
                    state_nxt = rw ? RLOAD : WDATA;
                end
                RLOAD: begin
                    sr_we     = 1'b1;
                    buf_e     = 1'b1;
                    state_nxt = RDATA;
                end
                RDATA: begin
                    // MISO moves on falls; stay one extra clk at the terminal
                    // count so an abort there is not reported as an error.
                    buf_e = 1'b1;
                    if (cnt == DATA_LAST) begin
                        state_nxt = DONE;
                    end else if (sclk_fall) begin
                        sr_shift = 1'b1;
                        cnt_nxt  = cnt + CNT_ONE;
                    end
                end
                WDATA: begin
                    if (sclk_rise && cnt != DATA_LAST) begin
                        sr_shift = 1'b1;
                        cnt_nxt  = cnt + CNT_ONE;
                        if (cnt + CNT_ONE == DATA_LAST) state_nxt = COMMIT;
                    end
                end
                COMMIT: begin
                    dm_we     = 1'b1;
                    state_nxt = DONE;
                end
                DONE: begin
                    // single-byte frames: further edges ignored until cs_n rises
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// tb_spi_slave_sequencer
//   Scoreboard bench: each stimulus task pushes the strobe events it expects
//   into a queue; a monitor on the falling clk edge pops and compares every
//   strobe the sequencer produces. Level outputs are checked directly.
module tb_spi_slave_sequencer;

    localparam int S = 2;  // SYNC_STAGES
    localparam int H = 6;  // sclk half period in clk cycles

    localparam int T_SH = 1, T_AD = 2, T_SR = 3, T_DM = 4, T_FE = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sclk_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
    logic mosi_s, sr_shift, addr_we, sr_we, dm_we, buf_e, busy, frame_err;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit buf_seen = 1'b0;
    int nstb;

    spi_slave_sequencer #(.SYNC_STAGES(S), .ADDR_BITS(7), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
        .mosi_s(mosi_s), .sr_shift(sr_shift), .addr_we(addr_we),
        .sr_we(sr_we), .dm_we(dm_we), .buf_e(buf_e), .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // event code: type, sclk pin level, buf_e, mosi_s
    function automatic int ev(input int t, input int s, input int b, input int m);
        return t * 8 + s * 4 + b * 2 + m;
    endfunction

    function automatic int outs();
        return int'({busy, buf_e, sr_shift, addr_we, sr_we, dm_we, frame_err});
    endfunction

    task automatic pop_cmp(input int e);
        if (exp_q.size() == 0) chk("unexpected_event", e, -1);
        else chk("event", e, exp_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (buf_e) buf_seen = 1'b1;
            nstb = int'(sr_shift) + int'(addr_we) + int'(sr_we) + int'(dm_we);
            if (nstb > 0) chk("exclusive", nstb, 1);
            if (sr_shift) pop_cmp(ev(T_SH, int'(sclk_in), int'(buf_e), buf_e ? 0 : int'(mosi_s)));
            if (addr_we)   pop_cmp(ev(T_AD, 0, int'(buf_e), 0));
            if (sr_we)     pop_cmp(ev(T_SR, 0, int'(buf_e), 0));
            if (dm_we)     pop_cmp(ev(T_DM, 0, int'(buf_e), 0));
            if (frame_err) pop_cmp(ev(T_FE, 0, int'(buf_e), 0));
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n master clock cycles, MSB first: data set while sclk low, then rise, fall
    task automatic send_rises(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi_in = b[i];
            wclk(H);
            sclk_in = 1'b1;
            wclk(H);
            sclk_in = 1'b0;
        end
    endtask

    task automatic push_rises(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) exp_q.push_back(ev(T_SH, 1, 0, int'(b[i])));
    endtask

    task automatic push_write(input logic [7:0] cmd, input logic [7:0] data);
        push_rises(cmd, 8);
        exp_q.push_back(ev(T_AD, 0, 0, 0));
        push_rises(data, 8);
        exp_q.push_back(ev(T_DM, 0, 0, 0));
    endtask

    task automatic push_read_head(input logic [7:0] cmd, input int falls);
        push_rises(cmd, 8);
        exp_q.push_back(ev(T_AD, 0, 0, 0));
        exp_q.push_back(ev(T_SR, 0, 1, 0));
        for (int i = 0; i < falls; i++) exp_q.push_back(ev(T_SH, 0, 1, 0));
    endtask

    task automatic frame_start();
        cs_n_in = 1'b0;
        wclk(H);
    endtask

    task automatic frame_end(input string tag);
        cs_n_in = 1'b1;
        wclk(S + 2);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic drain(input string tag);
        wclk(2);
        chk({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // reset state
        wclk(3);
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        wclk(3);
        chk("post_reset_outs", outs(), 0);

        // write frame: cmd 0xA8 (addr 0x54, rw=0), data 0x3C
        buf_seen = 1'b0;
        push_write(8'hA8, 8'h3C);
        frame_start();
        chk("wr_busy", int'(busy), 1);
        send_rises(8'hA8, 8);
        send_rises(8'h3C, 8);
        wclk(H);
        chk("wr_done_busy", int'(busy), 1);
        frame_end("wr");
        chk("wr_no_buf", int'(buf_seen), 0);
        drain("wr");

        // read frame: cmd 0x55 (addr 0x2A, rw=1)
        push_read_head(8'h55, 8);
        frame_start();
        send_rises(8'h55, 8);
        wclk(H);
        chk("rd_buf_on", int'(buf_e), 1);
        send_rises(8'h00, 8);
        wclk(H);
        chk("rd_done_buf", int'(buf_e), 0);
        chk("rd_done_busy", int'(busy), 1);
        frame_end("rd");
        drain("rd");

        // abort after 5 data rises of a write
        push_rises(8'hA8, 8);
        exp_q.push_back(ev(T_AD, 0, 0, 0));
        push_rises(8'h3C, 5);
        exp_q.push_back(ev(T_FE, 0, 0, 0));
        frame_start();
        send_rises(8'hA8, 8);
        send_rises(8'h3C, 5);
        wclk(H);
        frame_end("abort");
        drain("abort");

        // reset during RDATA
        push_read_head(8'h55, 3);
        frame_start();
        send_rises(8'h55, 8);
        send_rises(8'h00, 2);
        wclk(H);
        chk("rst_rd_buf", int'(buf_e), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", outs(), 0);
        cs_n_in = 1'b1;
        wclk(3);
        rst_n = 1'b1;
        wclk(S + 2);
        for (int i = 0; i < 4; i++) begin
            sclk_in = ~sclk_in;
            wclk(H);
        end
        chk("rst_idle", int'(busy), 0);
        drain("rst");

        // extra clocks: 20 rises in one write frame
        push_write(8'hA8, 8'h3C);
        frame_start();
        send_rises(8'hA8, 8);
        send_rises(8'h3C, 8);
        send_rises(8'h0F, 4);
        wclk(H);
        chk("extra_done_busy", int'(busy), 1);
        frame_end("extra");
        drain("extra");

        // back-to-back writes with a 4-clk cs_n-high gap
        push_write(8'hA8, 8'h3C);
        push_write(8'h22, 8'hC3);
        frame_start();
        send_rises(8'hA8, 8);
        send_rises(8'h3C, 8);
        wclk(H);
        cs_n_in = 1'b1;
        wclk(4);
        chk("b2b_gap_idle", int'(busy), 0);
        frame_start();
        send_rises(8'h22, 8);
        send_rises(8'hC3, 8);
        wclk(H);
        frame_end("b2b");
        drain("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
